// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch
//
// Purpose:
//   Decodes and executes one RV32I OP / OP-IMM instruction per cycle and
//   presents the result through a valid/ready output port. There is one
//   registered output entry plus a one-entry skid buffer, so in_ready can be
//   a plain register and still never drop an accepted instruction.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     instruction + operands presented
//   in_ready     registered; high while the skid entry is empty
//   in_instr     RV32I instruction word
//   in_rs1       operand A value
//   in_rs2       operand B value (ignored for OP-IMM)
//   out_valid    result entry present
//   out_ready    downstream accepts the result
//   out_rd       destination register index (instr[11:7])
//   out_result   ALU result (0 for illegal encodings)
//   out_we       write-back enable (0 for illegal or rd == x0)
//   out_illegal  instruction was not a supported OP/OP-IMM encoding
//   op_count     wrapping count of legal results handed downstream
// ---------------------------------------------------------------------------
module alu_dispatch #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_result,
   output logic             out_we,
   output logic             out_illegal,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   // One pipeline entry: everything the output port shows for a result.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] result;
      logic        we;
      logic        illegal;
   } entry_t;

   // Occupancy of the two entries. ST_FULL means output and skid both hold
   // an entry; the skid entry is never occupied while the output is empty.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_OUT   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // -----------------------------------------------------------------------
   // Decode
   // -----------------------------------------------------------------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd_idx;
   logic        is_op;
   logic        is_op_imm;
   logic [31:0] imm_sext;
   logic [31:0] operand_b;
   logic [4:0]  shamt;
   logic        legal;
   logic        alt_op;     // sub for OP funct3 000, arithmetic shift for 101

   assign opcode    = in_instr[6:0];
   assign funct3    = in_instr[14:12];
   assign funct7    = in_instr[31:25];
   assign rd_idx    = in_instr[11:7];
   assign is_op     = (opcode == OPC_OP);
   assign is_op_imm = (opcode == OPC_OP_IMM);
   assign imm_sext  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign operand_b = is_op_imm ? imm_sext : in_rs2;
   assign shamt     = operand_b[4:0];

   // Source-register index fields are not needed: operand values arrive
   // already read from the register file.
   logic unused_rs1_idx;
   assign unused_rs1_idx = &{1'b0, in_instr[19:15]};

   always_comb begin
      legal  = 1'b0;
      alt_op = 1'b0;
      if (is_op) begin
         if (funct7 == F7_BASE) begin
            legal = 1'b1;
         end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
            legal  = 1'b1;
            alt_op = 1'b1;
         end
      end else if (is_op_imm) begin
         // funct7 only exists for the immediate shifts; for every other
         // funct3 those bits are part of the immediate (addi never subtracts).
         case (funct3)
            3'b001: legal = (funct7 == F7_BASE);
            3'b101: begin
               legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               alt_op = (funct7 == F7_ALT);
            end
            default: legal = 1'b1;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Execute
   // -----------------------------------------------------------------------
   logic [31:0] and_bits;
   logic [31:0] or_bits;
   logic [31:0] xor_bits;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_bitwise
         assign and_bits[gi] = in_rs1[gi] & operand_b[gi];
         assign or_bits[gi]  = in_rs1[gi] | operand_b[gi];
         assign xor_bits[gi] = in_rs1[gi] ^ operand_b[gi];
      end
   endgenerate

   logic [31:0] alu_result;

   always_comb begin
      alu_result = 32'd0;
      case (funct3)
         3'b000: alu_result = alt_op ? (in_rs1 - operand_b) : (in_rs1 + operand_b);
         3'b001: alu_result = in_rs1 << shamt;
         3'b010: alu_result = {31'd0, ($signed(in_rs1) < $signed(operand_b))};
         3'b011: alu_result = {31'd0, (in_rs1 < operand_b)};
         3'b100: alu_result = xor_bits;
         3'b101: alu_result = alt_op ? $unsigned($signed(in_rs1) >>> shamt)
                                     : (in_rs1 >> shamt);
         3'b110: alu_result = or_bits;
         default: alu_result = and_bits;
      endcase
   end

   entry_t new_entry;

   always_comb begin
      new_entry.rd      = rd_idx;
      new_entry.result  = legal ? alu_result : 32'd0;
      new_entry.we      = legal && (rd_idx != 5'd0);
      new_entry.illegal = !legal;
   end

   // -----------------------------------------------------------------------
   // Output stage + skid buffer
   // -----------------------------------------------------------------------
   state_t           state_reg, state_next;
   entry_t           out_entry_reg, out_entry_next;
   entry_t           skid_entry_reg, skid_entry_next;
   logic             in_ready_reg, in_ready_next;
   logic [CNT_W-1:0] op_count_reg, op_count_next;

   logic accept;
   logic drain;

   assign accept = in_valid && in_ready_reg;
   assign drain  = (state_reg != ST_EMPTY) && out_ready;

   always_comb begin
      state_next      = state_reg;
      out_entry_next  = out_entry_reg;
      skid_entry_next = skid_entry_reg;

      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               out_entry_next = new_entry;
               state_next     = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               // Drain and refill on the same edge: no bubble.
               if (accept) begin
                  out_entry_next = new_entry;
               end else begin
                  state_next = ST_EMPTY;
               end
            end else if (accept) begin
               skid_entry_next = new_entry;
               state_next      = ST_FULL;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               // The older skid entry moves forward first so order is kept.
               out_entry_next = skid_entry_reg;
               if (accept) begin
                  skid_entry_next = new_entry;
               end else begin
                  state_next = ST_OUT;
               end
            end
         end
         default: state_next = ST_EMPTY;
      endcase

      // in_ready is computed from the next occupancy so it tracks the skid
      // entry exactly while still being a flop.
      in_ready_next = (state_next != ST_FULL);

      op_count_next = op_count_reg;
      if (drain && !out_entry_reg.illegal) begin
         op_count_next = op_count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_EMPTY;
         out_entry_reg  <= '0;
         skid_entry_reg <= '0;
         in_ready_reg   <= 1'b0;
         op_count_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         out_entry_reg  <= out_entry_next;
         skid_entry_reg <= skid_entry_next;
         in_ready_reg   <= in_ready_next;
         op_count_reg   <= op_count_next;
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = (state_reg != ST_EMPTY);
   assign out_rd      = out_entry_reg.rd;
   assign out_result  = out_entry_reg.result;
   assign out_we      = out_entry_reg.we;
   assign out_illegal = out_entry_reg.illegal;
   assign op_count    = op_count_reg;

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-operation counter op_count.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream presents an instruction plus operands.
REQ-005 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 in_instr  input  32  RV32I instruction word.
REQ-007 in_rs1 / in_rs2  input  32 each  register operand values.
REQ-008 out_valid  output  1  result entry present.
REQ-009 out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready at a rising edge.
REQ-010 out_rd  output  5  destination register index, instr[11:7].
REQ-011 out_result  output  32  computed ALU result.
REQ-012 out_we  output  1  write-back enable.
REQ-013 out_illegal  output  1  the instruction was not a supported OP/OP-IMM encoding.
REQ-014 op_count  output  CNT_W  count of legal results handed off downstream.

Function
REQ-015 Decode: opcode 0110011 (OP) uses operand B = in_rs2; opcode 0010011 (OP-IMM) uses B = sign-extended instr[31:20]; in_rs2 is ignored for OP-IMM.
REQ-016 funct3 mapping: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
REQ-017 OP: funct7 0100000 selects sub (funct3 000) or sra (funct3 101); funct7 0000000 selects the base op; every other funct7/funct3 combination is illegal.
REQ-018 OP-IMM: funct3 000 with instr[30]=1 is addi, not subtract; for funct3 001, funct7 is 0000000 (slli) or illegal; for funct3 101, funct7 is 0000000 (srli) or 0100000 (srai), otherwise illegal.
REQ-019 The shift amount is B[4:0].
REQ-020 sra/srai are arithmetic: sign is replicated from rs1[31].
REQ-021 slt compares signed; sltu compares unsigned.
REQ-022 Results are 0x00000000 or 0x00000001 for slt/sltu; add/sub wrap modulo 2^32.
REQ-023 Illegal opcode or encoding: out_illegal=1, out_we=0, out_result=0; out_rd still carries instr[11:7].
REQ-024 rd=0 on a legal op: out_we=0; out_result still carries the computed value.
REQ-025 Pipeline: a registered output stage plus a one-entry skid buffer.
REQ-026 Latency: an instruction accepted at edge N is visible on the outputs after edge N when the output stage is empty or draining at N.
REQ-027 Throughput is 1 instruction/cycle while out_ready=1.
REQ-028 While out_valid && !out_ready, out_rd, out_result, out_we and out_illegal hold stable.
REQ-029 Skid: an accept while the output stage holds an undrained entry goes to the skid entry.
REQ-030 in_ready is registered and equals !skid_full; it deasserts the cycle after the skid entry fills.
REQ-031 When the output drains and the skid entry is full, the skid entry moves to the output on that edge. A new accept on the same edge goes to the skid entry.
REQ-032 Results leave in acceptance order; no entry is dropped or duplicated.
REQ-033 op_count increments on each output transfer with out_illegal=0, including rd=0, and wraps from 2^CNT_W-1 to 0.
REQ-034 Simultaneous accept and drain with an empty skid entry: the new result replaces the output entry with no bubble.

Reset
REQ-035 On rst_n=0, immediately and regardless of clk: out_valid=0, out_rd=0, out_result=0, out_we=0, out_illegal=0, op_count=0, skid entry empty.
REQ-036 in_ready is 0 while rst_n=0 and 1 from the first rising edge after rst_n deasserts.
REQ-037 Reset mid-operation discards all in-flight entries; no partial transfer completes.

Verification
REQ-038 add x3,x1,x2 (0x002081B3), rs1=0xFFFFFFFF, rs2=0x00000002, out_ready=1 -> next cycle out_result=0x00000001, out_rd=3, out_we=1, op_count=1.
REQ-039 sub (0x402081B3) rs1=5, rs2=7 -> out_result=0xFFFFFFFE. slt x4,x1,x2 (0x0020A233) with rs1=0x80000000, rs2=1 -> out_result=0x00000001.
REQ-040 srai x5,x1,4 (0x4040D293), rs1=0x80000010 -> out_result=0xF8000001. addi x1,x0,-1 (0xFFF00093), rs1=0 -> out_result=0xFFFFFFFF.
REQ-041 Illegal word 0x0000006F, or OP with funct7=0000001 -> out_illegal=1, out_we=0, out_result=0, op_count unchanged.
REQ-042 Back-pressure: stream 4 adds with out_ready=0 -> after 2 accepts in_ready=0 and outputs stay stable; raise out_ready -> all 4 results appear in order, one per cycle, none lost.
REQ-043 Assert rst_n=0 with both entries full -> out_valid=0 and op_count=0 immediately; after release, the first new instruction yields a result with no stale entries.
